matmul_tile_sequencer: RTL and testbench
========================================

// Module: matmul_tile_sequencer
// PURPOSE
//  Parametrised memory sequencer for the systolic matmul: replaces the fixed 8x8 address muxes/counters.
//  Arbitrates host load/readback of the A/B/C BRAMs against compute. Streams K tiles of A/B rows into the
//  array with accumulate control, waits for completion with a timeout, then writes the C rows.
// PARAMETERS
//  MAT_SIZE   8     rows per tile; systolic array dimension
//  AWIDTH     7     BRAM address width
//  KTW        4     width of k_tiles; up to 2^KTW-1 K tiles per run
//  WAIT_MAX   255   max cycles in WAIT before timeout; 1..2^16-1
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high reset
//  host_wr_en   in   1       host write request (IDLE only)
//  host_rd_en   in   1       host read request (IDLE only)
//  host_sel     in   2       0=A 1=B 2=C 3=none(ack, no access)
//  host_addr    in   AWIDTH  host address
//  host_ack     out  1       access accepted; pulses one cycle after request
//  start        in   1       start pulse; a_base/b_base/c_base/k_tiles sampled with it
//  a_base       in   AWIDTH  A base row address
//  b_base       in   AWIDTH  B base row address
//  c_base       in   AWIDTH  C base row address
//  k_tiles      in   KTW     K tiles to accumulate
//  a_addr       out  AWIDTH  A BRAM address
//  b_addr       out  AWIDTH  B BRAM address
//  c_addr       out  AWIDTH  C BRAM address
//  a_we         out  1       A write enable
//  b_we         out  1       B write enable
//  c_we         out  1       C write enable
//  mm_valid     out  1       A/B row valid to array
//  mm_first     out  1       first tile: array clears accumulators
//  mm_done      in   1       array result-ready pulse
//  busy         out  1       state != IDLE
//  done         out  1       one-cycle completion pulse
//  timeout      out  1       sticky; set on WAIT expiry, cleared by next accepted start or reset
// BEHAVIOUR
//  Outputs are flops updated with state. Reset: state IDLE, all outputs and counters 0.
//  Reset mid-run aborts at once; no further we/valid.
//  IDLE: host access in cycle n -> addr/we on the selected port and host_ack=1 in cycle n+1.
//   Write: wr_en and sel=0/1/2 -> a_we/b_we/c_we=1. Read: addr driven, we=0.
//   wr_en and rd_en both high -> write. sel=3 -> ack only.
//   start beats host: same-cycle host request dropped, no ack. Requests while busy: ignored, no ack.
//   start with k_tiles==0 -> DONE next cycle, no memory ops.
//   Otherwise -> FETCH with tile=0, row=0; timeout cleared.
//  FETCH: row r of tile t drives mm_valid=1;
//   a_addr = a_base + t*MAT_SIZE + r, b_addr = b_base + t*MAT_SIZE + r.
//   Sums are truncated to AWIDTH (mod 2^AWIDTH wrap). mm_first=1 iff t==0.
//   After row MAT_SIZE-1: next tile, or WAIT when t==k_tiles-1. No bubbles: k_tiles*MAT_SIZE cycles.
//  WAIT: mm_valid=0; wait counter counts cycles.
//   mm_done -> DRAIN. Counter reaching WAIT_MAX -> timeout=1, IDLE, no done.
//   mm_done outside WAIT is ignored.
//  DRAIN: MAT_SIZE cycles with c_we=1 and c_addr = c_base + r, wrapping mod 2^AWIDTH; then DONE.
//  DONE: done=1 for one cycle, all we=0 -> IDLE. busy=0 in the done cycle.
//  start while busy: ignored.
// TESTING
//  Defaults; A host write sel=0 addr=5, then read sel=2 addr=9:
//   a_we=1 a_addr=5 ack; then c_addr=9 c_we=0 ack.
//  start, k_tiles=2, bases 0/16/32:
//   16 valid cycles, a_addr 0..15, b_addr 16..31, mm_first high for first 8.
//   mm_done 3 cycles later -> c_we 8 cycles c_addr 32..39 -> single done.
//  a_base=124 k_tiles=1: a_addr 124..127,0..3 (wrap).
//  No mm_done: timeout=1 after 255 WAIT cycles, back to IDLE, done never asserted.
//   Next start clears timeout.
//  start with same-cycle host_wr_en: no a_we, no ack, FETCH proceeds.
//   k_tiles=0: done next cycle, no we.
//  reset asserted mid-FETCH (row 3): next cycle busy=0, mm_valid=0, all addr=0.
//   Fresh start then behaves normally.

Source files
------------

// File: rtl/matmul_tile_sequencer_if.sv
// rtl/matmul_tile_sequencer_if.sv - host, control, BRAM and array signals of the matmul tile sequencer
interface matmul_tile_sequencer_if #(
    parameter int AWIDTH = 7,
    parameter int KTW    = 4
);
    logic              host_wr_en;
    logic              host_rd_en;
    logic [1:0]        host_sel;
    logic [AWIDTH-1:0] host_addr;
    logic              host_ack;
    logic              start;
    logic [AWIDTH-1:0] a_base;
    logic [AWIDTH-1:0] b_base;
    logic [AWIDTH-1:0] c_base;
    logic [KTW-1:0]    k_tiles;
    logic [AWIDTH-1:0] a_addr;
    logic [AWIDTH-1:0] b_addr;
    logic [AWIDTH-1:0] c_addr;
    logic              a_we;
    logic              b_we;
    logic              c_we;
    logic              mm_valid;
    logic              mm_first;
    logic              mm_done;
    logic              busy;
    logic              done;
    logic              timeout;

    modport master (
        output host_wr_en, host_rd_en, host_sel, host_addr,
        output start, a_base, b_base, c_base, k_tiles, mm_done,
        input  host_ack, a_addr, b_addr, c_addr, a_we, b_we, c_we,
        input  mm_valid, mm_first, busy, done, timeout
    );

    modport slave (
        input  host_wr_en, host_rd_en, host_sel, host_addr,
        input  start, a_base, b_base, c_base, k_tiles, mm_done,
        output host_ack, a_addr, b_addr, c_addr, a_we, b_we, c_we,
        output mm_valid, mm_first, busy, done, timeout
    );
endinterface

// File: rtl/matmul_tile_sequencer.sv
// rtl/matmul_tile_sequencer.sv - BRAM address sequencer arbitrating host access against tiled systolic compute
module matmul_tile_sequencer #(
    parameter int MAT_SIZE = 8,
    parameter int AWIDTH   = 7,
    parameter int KTW      = 4,
    parameter int WAIT_MAX = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    matmul_tile_sequencer_if.slave   bus
);
    localparam int RW = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;
    localparam logic [RW-1:0] ROW_LAST  = RW'(MAT_SIZE - 1);
    localparam logic [15:0]   WAIT_LAST = 16'(WAIT_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [RW-1:0]     row;
    logic [KTW-1:0]    tile;
    logic [KTW-1:0]    k_reg;
    logic [AWIDTH-1:0] c_base_reg;
    logic [15:0]       wait_cnt;

    logic              host_ack;
    logic [AWIDTH-1:0] a_addr;
    logic [AWIDTH-1:0] b_addr;
    logic [AWIDTH-1:0] c_addr;
    logic              a_we;
    logic              b_we;
    logic              c_we;
    logic              mm_valid;
    logic              mm_first;
    logic              busy;
    logic              done;
    logic              timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            row        <= '0;
            tile       <= '0;
            k_reg      <= '0;
            c_base_reg <= '0;
            wait_cnt   <= '0;
            host_ack   <= 1'b0;
            a_addr     <= '0;
            b_addr     <= '0;
            c_addr     <= '0;
            a_we       <= 1'b0;
            b_we       <= 1'b0;
            c_we       <= 1'b0;
            mm_valid   <= 1'b0;
            mm_first   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            host_ack <= 1'b0;
            a_we     <= 1'b0;
            b_we     <= 1'b0;
            c_we     <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    // start wins over a same-cycle host request, which is dropped unacknowledged
                    if (bus.start) begin
                        timeout    <= 1'b0;
                        k_reg      <= bus.k_tiles;
                        c_base_reg <= bus.c_base;
                        if (bus.k_tiles == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= S_FETCH;
                            busy     <= 1'b1;
                            a_addr   <= bus.a_base;
                            b_addr   <= bus.b_base;
                            mm_valid <= 1'b1;
                            mm_first <= 1'b1;
                            row      <= '0;
                            tile     <= '0;
                        end
                    end else if (bus.host_wr_en || bus.host_rd_en) begin
                        host_ack <= 1'b1;
                        case (bus.host_sel)
                            2'd0: begin
                                a_addr <= bus.host_addr;
                                a_we   <= bus.host_wr_en;
                            end
                            2'd1: begin
                                b_addr <= bus.host_addr;
                                b_we   <= bus.host_wr_en;
                            end
                            2'd2: begin
                                c_addr <= bus.host_addr;
                                c_we   <= bus.host_wr_en;
                            end
                            default: ;
                        endcase
                    end
                end
                S_FETCH: begin
                    // tiles are contiguous rows, so the address simply advances by one per row
                    if (row == ROW_LAST) begin
                        row <= '0;
                        if (tile + KTW'(1) == k_reg) begin
                            state    <= S_WAIT;
                            mm_valid <= 1'b0;
                            mm_first <= 1'b0;
                            wait_cnt <= '0;
                        end else begin
                            tile     <= tile + KTW'(1);
                            mm_first <= 1'b0;
                            a_addr   <= a_addr + AWIDTH'(1);
                            b_addr   <= b_addr + AWIDTH'(1);
                        end
                    end else begin
                        row    <= row + RW'(1);
                        a_addr <= a_addr + AWIDTH'(1);
                        b_addr <= b_addr + AWIDTH'(1);
                    end
                end
                S_WAIT: begin
                    if (bus.mm_done) begin
                        state  <= S_DRAIN;
                        c_addr <= c_base_reg;
                        c_we   <= 1'b1;
                        row    <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (row == ROW_LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        row    <= row + RW'(1);
                        c_addr <= c_addr + AWIDTH'(1);
                        c_we   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.host_ack = host_ack;
    assign bus.a_addr   = a_addr;
    assign bus.b_addr   = b_addr;
    assign bus.c_addr   = c_addr;
    assign bus.a_we     = a_we;
    assign bus.b_we     = b_we;
    assign bus.c_we     = c_we;
    assign bus.mm_valid = mm_valid;
    assign bus.mm_first = mm_first;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.timeout  = timeout;
endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// tb/tb_matmul_tile_sequencer.sv - directed self-checking bench for matmul_tile_sequencer
module tb_matmul_tile_sequencer;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    matmul_tile_sequencer_if #(.AWIDTH(7), .KTW(4)) bus ();

    matmul_tile_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.busy, bus.done, bus.timeout, bus.mm_valid, bus.mm_first, bus.host_ack,
             bus.a_we, bus.b_we, bus.c_we} !== 9'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0", {bus.busy, bus.done, bus.timeout, bus.mm_valid,
                     bus.mm_first, bus.host_ack, bus.a_we, bus.b_we, bus.c_we});
        end
        total++;
        if ({bus.a_addr, bus.b_addr, bus.c_addr} !== 21'b0) begin
            bad++;
            $display("FAIL reset_addr got=%h want=0", {bus.a_addr, bus.b_addr, bus.c_addr});
        end
        reset = 1'b0;
    endtask

    task automatic test_host_access();
        bus.host_wr_en = 1'b1; bus.host_rd_en = 1'b0; bus.host_sel = 2'd0; bus.host_addr = 7'd5;
        tick();
        total++;
        if ({bus.host_ack, bus.a_we, bus.b_we, bus.c_we, bus.a_addr} !== {4'b1100, 7'd5}) begin
            bad++;
            $display("FAIL host_write_a got=%h want=%h",
                     {bus.host_ack, bus.a_we, bus.b_we, bus.c_we, bus.a_addr}, {4'b1100, 7'd5});
        end
        bus.host_wr_en = 1'b0; bus.host_rd_en = 1'b1; bus.host_sel = 2'd2; bus.host_addr = 7'd9;
        tick();
        total++;
        if ({bus.host_ack, bus.a_we, bus.b_we, bus.c_we, bus.c_addr} !== {4'b1000, 7'd9}) begin
            bad++;
            $display("FAIL host_read_c got=%h want=%h",
                     {bus.host_ack, bus.a_we, bus.b_we, bus.c_we, bus.c_addr}, {4'b1000, 7'd9});
        end
        bus.host_wr_en = 1'b1; bus.host_rd_en = 1'b1; bus.host_sel = 2'd1; bus.host_addr = 7'd7;
        tick();
        total++;
        if ({bus.host_ack, bus.a_we, bus.b_we, bus.c_we, bus.b_addr} !== {4'b1010, 7'd7}) begin
            bad++;
            $display("FAIL host_wr_rd_b got=%h want=%h",
                     {bus.host_ack, bus.a_we, bus.b_we, bus.c_we, bus.b_addr}, {4'b1010, 7'd7});
        end
        bus.host_wr_en = 1'b1; bus.host_rd_en = 1'b0; bus.host_sel = 2'd3; bus.host_addr = 7'd100;
        tick();
        total++;
        if ({bus.host_ack, bus.a_we, bus.b_we, bus.c_we} !== 4'b1000) begin
            bad++;
            $display("FAIL host_sel3 got=%b want=1000", {bus.host_ack, bus.a_we, bus.b_we, bus.c_we});
        end
        bus.host_wr_en = 1'b0; bus.host_rd_en = 1'b0; bus.host_sel = 2'd0;
        tick();
        total++;
        if ({bus.host_ack, bus.a_we, bus.b_we, bus.c_we} !== 4'b0000) begin
            bad++;
            $display("FAIL host_idle got=%b want=0000", {bus.host_ack, bus.a_we, bus.b_we, bus.c_we});
        end
    endtask

    task automatic test_fetch_drain();
        bus.a_base = 7'd0; bus.b_base = 7'd16; bus.c_base = 7'd32; bus.k_tiles = 4'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if ({bus.mm_valid, bus.busy, bus.mm_first, bus.a_addr, bus.b_addr} !==
                {2'b11, (i < 8), 7'(i), 7'(16 + i)}) begin
                bad++;
                $display("FAIL fetch_row%0d got v=%b bz=%b f=%b a=%0d b=%0d want f=%b a=%0d b=%0d", i,
                         bus.mm_valid, bus.busy, bus.mm_first, bus.a_addr, bus.b_addr, (i < 8), i, 16 + i);
            end
            tick();
        end
        total++;
        if ({bus.mm_valid, bus.busy, bus.done} !== 3'b010) begin
            bad++;
            $display("FAIL wait_state got=%b want=010", {bus.mm_valid, bus.busy, bus.done});
        end
        tick();
        tick();
        bus.mm_done = 1'b1;
        tick();
        bus.mm_done = 1'b0;
        for (int j = 0; j < 8; j++) begin
            total++;
            if ({bus.c_we, bus.done, bus.busy, bus.c_addr} !== {3'b101, 7'(32 + j)}) begin
                bad++;
                $display("FAIL drain_row%0d got we=%b d=%b bz=%b c=%0d want c=%0d", j,
                         bus.c_we, bus.done, bus.busy, bus.c_addr, 32 + j);
            end
            tick();
        end
        total++;
        if ({bus.done, bus.busy, bus.c_we, bus.mm_valid} !== 4'b1000) begin
            bad++;
            $display("FAIL done_pulse got=%b want=1000", {bus.done, bus.busy, bus.c_we, bus.mm_valid});
        end
        tick();
        total++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            bad++;
            $display("FAIL done_single got=%b want=00", {bus.done, bus.busy});
        end
    endtask

    task automatic test_wrap();
        logic [6:0] exp_a;
        logic [6:0] exp_c;
        bus.a_base = 7'd124; bus.b_base = 7'd0; bus.c_base = 7'd124; bus.k_tiles = 4'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_a = 7'd124 + 7'(i);
            total++;
            if ({bus.mm_valid, bus.mm_first, bus.a_addr} !== {2'b11, exp_a}) begin
                bad++;
                $display("FAIL wrap_a_row%0d got v=%b f=%b a=%0d want a=%0d", i,
                         bus.mm_valid, bus.mm_first, bus.a_addr, exp_a);
            end
            tick();
        end
        bus.mm_done = 1'b1;
        tick();
        bus.mm_done = 1'b0;
        for (int j = 0; j < 8; j++) begin
            exp_c = 7'd124 + 7'(j);
            total++;
            if ({bus.c_we, bus.c_addr} !== {1'b1, exp_c}) begin
                bad++;
                $display("FAIL wrap_c_row%0d got we=%b c=%0d want c=%0d", j, bus.c_we, bus.c_addr, exp_c);
            end
            tick();
        end
        total++;
        if (bus.done !== 1'b1) begin
            bad++;
            $display("FAIL wrap_done got=%b want=1", bus.done);
        end
        tick();
    endtask

    task automatic test_timeout();
        int n;
        int done_seen;
        bus.a_base = 7'd0; bus.b_base = 7'd0; bus.c_base = 7'd0; bus.k_tiles = 4'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mm_done = 1'b1;
        tick();
        bus.mm_done = 1'b0;
        for (int i = 1; i < 8; i++) tick();
        n = 0;
        done_seen = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            n++;
            if (bus.done === 1'b1 || bus.c_we === 1'b1) done_seen++;
            tick();
        end
        total++;
        if (n !== 255) begin
            bad++;
            $display("FAIL timeout_cycles got=%0d want=255", n);
        end
        total++;
        if ({bus.timeout, bus.busy, bus.done, bus.mm_valid} !== 4'b1000) begin
            bad++;
            $display("FAIL timeout_flag got=%b want=1000", {bus.timeout, bus.busy, bus.done, bus.mm_valid});
        end
        total++;
        if (done_seen !== 0) begin
            bad++;
            $display("FAIL timeout_no_done got=%0d want=0", done_seen);
        end
        tick();
        total++;
        if (bus.timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky got=%b want=1", bus.timeout);
        end
    endtask

    task automatic test_start_priority_and_reset();
        bus.a_base = 7'd10; bus.b_base = 7'd20; bus.c_base = 7'd30; bus.k_tiles = 4'd1;
        bus.start = 1'b1; bus.host_wr_en = 1'b1; bus.host_sel = 2'd0; bus.host_addr = 7'd50;
        tick();
        bus.start = 1'b0; bus.host_wr_en = 1'b0;
        total++;
        if ({bus.host_ack, bus.a_we, bus.mm_valid, bus.busy, bus.timeout, bus.a_addr} !==
            {5'b00110, 7'd10}) begin
            bad++;
            $display("FAIL start_beats_host got=%h want=%h",
                     {bus.host_ack, bus.a_we, bus.mm_valid, bus.busy, bus.timeout, bus.a_addr},
                     {5'b00110, 7'd10});
        end
        bus.host_wr_en = 1'b1; bus.host_sel = 2'd1; bus.host_addr = 7'd99;
        tick();
        total++;
        if ({bus.host_ack, bus.b_we, bus.b_addr} !== {2'b00, 7'd21}) begin
            bad++;
            $display("FAIL busy_host_ignored got=%h want=%h", {bus.host_ack, bus.b_we, bus.b_addr}, {2'b00, 7'd21});
        end
        bus.host_wr_en = 1'b0;
        tick();
        tick();
        total++;
        if ({bus.mm_valid, bus.a_addr} !== {1'b1, 7'd13}) begin
            bad++;
            $display("FAIL fetch_row3 got v=%b a=%0d want a=13", bus.mm_valid, bus.a_addr);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({bus.busy, bus.mm_valid, bus.a_addr, bus.b_addr, bus.c_addr} !== 23'b0) begin
            bad++;
            $display("FAIL reset_midrun got=%h want=0",
                     {bus.busy, bus.mm_valid, bus.a_addr, bus.b_addr, bus.c_addr});
        end
        bus.a_base = 7'd2; bus.b_base = 7'd3; bus.c_base = 7'd4; bus.k_tiles = 4'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if ({bus.mm_valid, bus.mm_first, bus.busy, bus.a_addr, bus.b_addr} !== {3'b111, 7'd2, 7'd3}) begin
            bad++;
            $display("FAIL fresh_start got=%h want=%h",
                     {bus.mm_valid, bus.mm_first, bus.busy, bus.a_addr, bus.b_addr}, {3'b111, 7'd2, 7'd3});
        end
        for (int i = 0; i < 8; i++) tick();
        bus.mm_done = 1'b1;
        tick();
        bus.mm_done = 1'b0;
        total++;
        if ({bus.c_we, bus.c_addr} !== {1'b1, 7'd4}) begin
            bad++;
            $display("FAIL fresh_drain got we=%b c=%0d want we=1 c=4", bus.c_we, bus.c_addr);
        end
        for (int j = 0; j < 8; j++) tick();
        total++;
        if ({bus.done, bus.busy} !== 2'b10) begin
            bad++;
            $display("FAIL fresh_done got=%b want=10", {bus.done, bus.busy});
        end
        tick();
    endtask

    task automatic test_zero_tiles();
        bus.k_tiles = 4'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        total++;
        if ({bus.done, bus.busy, bus.mm_valid, bus.a_we, bus.b_we, bus.c_we} !== 6'b100000) begin
            bad++;
            $display("FAIL zero_tiles got=%b want=100000",
                     {bus.done, bus.busy, bus.mm_valid, bus.a_we, bus.b_we, bus.c_we});
        end
        tick();
        total++;
        if ({bus.done, bus.busy, bus.c_we} !== 3'b000) begin
            bad++;
            $display("FAIL zero_tiles_after got=%b want=000", {bus.done, bus.busy, bus.c_we});
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.host_wr_en = 1'b0;
        bus.host_rd_en = 1'b0;
        bus.host_sel   = 2'd0;
        bus.host_addr  = '0;
        bus.start      = 1'b0;
        bus.a_base     = '0;
        bus.b_base     = '0;
        bus.c_base     = '0;
        bus.k_tiles    = '0;
        bus.mm_done    = 1'b0;
        test_reset();
        test_host_access();
        test_fetch_drain();
        test_wrap();
        test_timeout();
        test_start_priority_and_reset();
        test_zero_tiles();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
